// File: rtl/lift_group_dispatcher.sv
// Two-car hall-call dispatcher: latches landing calls, assigns each to the cheaper car, clears on service.
// Build option DISPATCH_STATS_EN adds saturating per-car assignment counters.
module lift_group_dispatcher #(
   parameter int N_FLOORS = 12,
   parameter int FLR_W    = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] hall_up_rqst,
   input  logic [N_FLOORS-1:0] hall_dn_rqst,
   input  logic [1:0]          car_enable,
   input  logic [FLR_W-1:0]    car0_floor,
   input  logic [FLR_W-1:0]    car1_floor,
   input  logic                car0_direction,
   input  logic                car1_direction,
   input  logic                car0_motion,
   input  logic                car1_motion,
   input  logic                car0_door_open,
   input  logic                car1_door_open,
   output logic [N_FLOORS-1:0] car0_up_assign,
   output logic [N_FLOORS-1:0] car0_dn_assign,
   output logic [N_FLOORS-1:0] car1_up_assign,
   output logic [N_FLOORS-1:0] car1_dn_assign,
`ifdef DISPATCH_STATS_EN
   output logic [15:0]         car0_assign_cnt,
   output logic [15:0]         car1_assign_cnt,
`endif
   output logic [N_FLOORS-1:0] hall_up_pending,
   output logic [N_FLOORS-1:0] hall_dn_pending
);
   localparam int                IDX_W    = $clog2(2*N_FLOORS);
   localparam int                CW       = FLR_W + 2;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(2*N_FLOORS-1);
   localparam logic [IDX_W-1:0]  DN_BASE  = IDX_W'(N_FLOORS);
   localparam logic [N_FLOORS-1:0] UP_OK  = {1'b0, {(N_FLOORS-1){1'b1}}};
   localparam logic [N_FLOORS-1:0] DN_OK  = {{(N_FLOORS-1){1'b1}}, 1'b0};

   typedef enum logic [1:0] {IDLE, SCAN, RELEASE} state_t;

   state_t              state_q, state_d;
   logic [N_FLOORS-1:0] pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
   logic [N_FLOORS-1:0] a0_up_q, a0_up_d, a0_dn_q, a0_dn_d;
   logic [N_FLOORS-1:0] a1_up_q, a1_up_d, a1_dn_q, a1_dn_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                rr_q, rr_d;
   logic [1:0]          en_q, en_d;

   logic [N_FLOORS-1:0] free_up, free_dn, sup_up, sup_dn;
   logic [N_FLOORS-1:0] srv0_up, srv0_dn, srv1_up, srv1_dn;
   logic                fall, any_free, scan_act, call_dn, call_free, give0, give1;
   logic [IDX_W-1:0]    idx_off;
   logic [FLR_W-1:0]    call_flr;
   logic [CW-1:0]       cost0, cost1;

   function automatic logic [N_FLOORS-1:0] flr_hot(input logic [FLR_W-1:0] f);
      return {{(N_FLOORS-1){1'b0}}, 1'b1} << f;
   endfunction

   // Moving cars pay a full-shaft penalty when heading away from the call or against its direction.
   function automatic logic [CW-1:0] call_cost(input logic [FLR_W-1:0] cf, input logic cdir,
                                               input logic cmov, input logic [FLR_W-1:0] f,
                                               input logic up);
      logic [CW-1:0] c;
      logic          away;
      c    = (f >= cf) ? CW'(f - cf) : CW'(cf - f);
      away = cdir ? (f < cf) : (f > cf);
      if (cmov && (away || (cdir != up))) c = c + CW'(N_FLOORS);
      return c;
   endfunction

   always_comb begin
      fall     = |(en_q & ~car_enable);
      free_up  = pend_up_q & ~(a0_up_q | a1_up_q);
      free_dn  = pend_dn_q & ~(a0_dn_q | a1_dn_q);
      any_free = |{free_up, free_dn};
      scan_act = !fall && ((state_q == SCAN) || (state_q == IDLE && any_free));

      sup_up = '0;
      sup_dn = '0;
      if (car_enable[0] && car0_door_open) begin
         if (car0_direction) sup_up = sup_up | flr_hot(car0_floor);
         else                sup_dn = sup_dn | flr_hot(car0_floor);
      end
      if (car_enable[1] && car1_door_open) begin
         if (car1_direction) sup_up = sup_up | flr_hot(car1_floor);
         else                sup_dn = sup_dn | flr_hot(car1_floor);
      end
      srv0_up = car0_door_open ? (flr_hot(car0_floor) & a0_up_q) : '0;
      srv0_dn = car0_door_open ? (flr_hot(car0_floor) & a0_dn_q) : '0;
      srv1_up = car1_door_open ? (flr_hot(car1_floor) & a1_up_q) : '0;
      srv1_dn = car1_door_open ? (flr_hot(car1_floor) & a1_dn_q) : '0;

      call_dn   = idx_q >= DN_BASE;
      idx_off   = call_dn ? (idx_q - DN_BASE) : idx_q;
      call_flr  = FLR_W'(idx_off);
      call_free = call_dn ? free_dn[call_flr] : free_up[call_flr];
      cost0     = call_cost(car0_floor, car0_direction, car0_motion, call_flr, ~call_dn);
      cost1     = call_cost(car1_floor, car1_direction, car1_motion, call_flr, ~call_dn);

      give0 = 1'b0;
      give1 = 1'b0;
      rr_d  = rr_q;
      if (scan_act && call_free) begin
         if (car_enable == 2'b11) begin
            if (cost0 < cost1)      give0 = 1'b1;
            else if (cost1 < cost0) give1 = 1'b1;
            else begin
               give0 = ~rr_q;
               give1 = rr_q;
               rr_d  = ~rr_q;
            end
         end else begin
            give0 = car_enable[0];
            give1 = car_enable[1];
         end
      end

      pend_up_d = (pend_up_q | (hall_up_rqst & UP_OK & ~sup_up)) & ~(srv0_up | srv1_up);
      pend_dn_d = (pend_dn_q | (hall_dn_rqst & DN_OK & ~sup_dn)) & ~(srv0_dn | srv1_dn);
      a0_up_d   = a0_up_q & ~srv0_up;
      a0_dn_d   = a0_dn_q & ~srv0_dn;
      a1_up_d   = a1_up_q & ~srv1_up;
      a1_dn_d   = a1_dn_q & ~srv1_dn;
      if (give0) begin
         if (call_dn) a0_dn_d[call_flr] = 1'b1;
         else         a0_up_d[call_flr] = 1'b1;
      end
      if (give1) begin
         if (call_dn) a1_dn_d[call_flr] = 1'b1;
         else         a1_up_d[call_flr] = 1'b1;
      end
      // An out-of-service car drops everything; pending calls stay lit and are re-dispatched.
      if (!car_enable[0]) begin
         a0_up_d = '0;
         a0_dn_d = '0;
      end
      if (!car_enable[1]) begin
         a1_up_d = '0;
         a1_dn_d = '0;
      end

      idx_d = idx_q;
      if (scan_act) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
      en_d = car_enable;

      state_d = state_q;
      unique case (state_q)
         IDLE:    if (fall) state_d = RELEASE; else if (any_free)  state_d = SCAN;
         SCAN:    if (fall) state_d = RELEASE; else if (!any_free) state_d = IDLE;
         RELEASE: state_d = SCAN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         pend_up_q <= '0;
         pend_dn_q <= '0;
         a0_up_q   <= '0;
         a0_dn_q   <= '0;
         a1_up_q   <= '0;
         a1_dn_q   <= '0;
         idx_q     <= '0;
         rr_q      <= 1'b0;
         en_q      <= '0;
      end else begin
         state_q   <= state_d;
         pend_up_q <= pend_up_d;
         pend_dn_q <= pend_dn_d;
         a0_up_q   <= a0_up_d;
         a0_dn_q   <= a0_dn_d;
         a1_up_q   <= a1_up_d;
         a1_dn_q   <= a1_dn_d;
         idx_q     <= idx_d;
         rr_q      <= rr_d;
         en_q      <= en_d;
      end
   end

   assign car0_up_assign  = a0_up_q;
   assign car0_dn_assign  = a0_dn_q;
   assign car1_up_assign  = a1_up_q;
   assign car1_dn_assign  = a1_dn_q;
   assign hall_up_pending = pend_up_q;
   assign hall_dn_pending = pend_dn_q;

`ifdef DISPATCH_STATS_EN
   logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      if (give0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
      if (give1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign car0_assign_cnt = cnt0_q;
   assign car1_assign_cnt = cnt1_q;
`else
   // Statistics build option off: assignments are not counted.
`endif
endmodule

// File: tb/tb_lift_group_dispatcher.sv
// Bench for lift_group_dispatcher: directed scenarios plus randomized single calls scored against a cost model.
module tb_lift_group_dispatcher;
   localparam int N = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [N-1:0]  hall_up_rqst, hall_dn_rqst;
   logic [1:0]    car_enable;
   logic [3:0]    car0_floor, car1_floor;
   logic          car0_direction, car1_direction, car0_motion, car1_motion;
   logic          car0_door_open, car1_door_open;
   logic [N-1:0]  car0_up_assign, car0_dn_assign, car1_up_assign, car1_dn_assign;
   logic [N-1:0]  hall_up_pending, hall_dn_pending;
`ifdef DISPATCH_STATS_EN
   logic [15:0]   car0_assign_cnt, car1_assign_cnt;
`endif

   lift_group_dispatcher #(.N_FLOORS(N), .FLR_W(4)) dut (
      .clk(clk), .reset(rst_n),
      .hall_up_rqst(hall_up_rqst), .hall_dn_rqst(hall_dn_rqst), .car_enable(car_enable),
      .car0_floor(car0_floor), .car1_floor(car1_floor),
      .car0_direction(car0_direction), .car1_direction(car1_direction),
      .car0_motion(car0_motion), .car1_motion(car1_motion),
      .car0_door_open(car0_door_open), .car1_door_open(car1_door_open),
      .car0_up_assign(car0_up_assign), .car0_dn_assign(car0_dn_assign),
      .car1_up_assign(car1_up_assign), .car1_dn_assign(car1_dn_assign),
`ifdef DISPATCH_STATS_EN
      .car0_assign_cnt(car0_assign_cnt), .car1_assign_cnt(car1_assign_cnt),
`endif
      .hall_up_pending(hall_up_pending), .hall_dn_pending(hall_dn_pending)
   );

   int       n_checks = 0;
   int       n_fail   = 0;
   int       exp_q[$];
   int       exp_cnt[2];
   bit       rr_model;
   logic [N-1:0] prev[4];
   logic [N-1:0] cur[4];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: each newly raised assign bit must match the next scoreboard entry (car*2+dn)*100+floor.
   always @(negedge clk) begin
      cur[0] = car0_up_assign;
      cur[1] = car0_dn_assign;
      cur[2] = car1_up_assign;
      cur[3] = car1_dn_assign;
      if (rst_n) begin
         for (int v = 0; v < 4; v++)
            for (int f = 0; f < N; f++)
               if (cur[v][f] && !prev[v][f]) begin
                  if (exp_q.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_assign: car%0d %s floor %0d, expected none", v / 2,
                              (v % 2) ? "dn" : "up", f);
                  end else begin
                     check("assign_target", 64'(v * 100 + f), 64'(exp_q.pop_front()));
                  end
               end
         check("no_double_assign", 64'((car0_up_assign & car1_up_assign) |
                                       (car0_dn_assign & car1_dn_assign)), 64'd0);
         check("assign_has_pending", 64'(((car0_up_assign | car1_up_assign) & ~hall_up_pending) |
                                         ((car0_dn_assign | car1_dn_assign) & ~hall_dn_pending)), 64'd0);
      end
      for (int v = 0; v < 4; v++) prev[v] = cur[v];
   end

   function automatic int model_cost(int fl, bit dir, bit mov, bit en, int f, bit up);
      int c;
      if (!en) return 1000;
      c = (f > fl) ? f - fl : fl - f;
      if (mov && ((dir && f < fl) || (!dir && f > fl) || (dir != up))) c += N;
      return c;
   endfunction

   task automatic expect_call(input int f, input bit up, output int k);
      int c0, c1;
      c0 = model_cost(int'(car0_floor), car0_direction, car0_motion, car_enable[0], f, up);
      c1 = model_cost(int'(car1_floor), car1_direction, car1_motion, car_enable[1], f, up);
      if (c0 >= 1000 && c1 >= 1000) k = -1;
      else if (c0 < c1) k = 0;
      else if (c1 < c0) k = 1;
      else begin
         k = int'(rr_model);
         rr_model = !rr_model;
      end
      if (k >= 0) begin
         exp_q.push_back((k * 2 + (up ? 0 : 1)) * 100 + f);
         exp_cnt[k]++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d assignments outstanding after %0d cycles, expected 0", name,
                  exp_q.size(), budget);
         exp_q.delete();
      end
   endtask

   task automatic call(input int f, input bit up, input string name, output int k);
      logic [N-1:0] pv;
      expect_call(f, up, k);
      if (up) hall_up_rqst[f] = 1'b1;
      else    hall_dn_rqst[f] = 1'b1;
      tick();
      hall_up_rqst = '0;
      hall_dn_rqst = '0;
      pv = up ? hall_up_pending : hall_dn_pending;
      check({name, "_pending"}, 64'(pv[f]), 64'd1);
      wait_drain({name, "_assign"}, 2 * N + 3);
   endtask

   task automatic serve(input int k, input int f, input bit up);
      logic [N-1:0] pv, av;
      if (k == 0) begin
         car0_floor = 4'(f); car0_direction = up; car0_door_open = 1'b1;
      end else begin
         car1_floor = 4'(f); car1_direction = up; car1_door_open = 1'b1;
      end
      tick();
      pv = up ? hall_up_pending : hall_dn_pending;
      if (k == 0) av = up ? car0_up_assign : car0_dn_assign;
      else        av = up ? car1_up_assign : car1_dn_assign;
      check("serve_pending_clr", 64'(pv[f]), 64'd0);
      check("serve_assign_clr", 64'(av[f]), 64'd0);
      car0_door_open = 1'b0;
      car1_door_open = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_c0up"}, 64'(car0_up_assign), 64'd0);
      check({name, "_c0dn"}, 64'(car0_dn_assign), 64'd0);
      check({name, "_c1up"}, 64'(car1_up_assign), 64'd0);
      check({name, "_c1dn"}, 64'(car1_dn_assign), 64'd0);
      check({name, "_pup"},  64'(hall_up_pending), 64'd0);
      check({name, "_pdn"},  64'(hall_dn_pending), 64'd0);
`ifdef DISPATCH_STATS_EN
      check({name, "_cnt0"}, 64'(car0_assign_cnt), 64'd0);
      check({name, "_cnt1"}, 64'(car1_assign_cnt), 64'd0);
`endif
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      rr_model = 1'b0;
      exp_cnt[0] = 0;
      exp_cnt[1] = 0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      int k, f;
      bit up;
      rst_n = 1'b0;
      hall_up_rqst = '0; hall_dn_rqst = '0; car_enable = 2'b11;
      car0_floor = 4'd0; car1_floor = 4'd6;
      car0_direction = 1'b0; car1_direction = 1'b0; car0_motion = 1'b0; car1_motion = 1'b0;
      car0_door_open = 1'b0; car1_door_open = 1'b0;
      exp_cnt[0] = 0; exp_cnt[1] = 0; rr_model = 1'b0;
      repeat (2) tick();
      check_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Held up call at 3: equal distance from floors 0 and 6, car0 wins the first tie.
      expect_call(3, 1'b1, k);
      hall_up_rqst = 12'h008;
      tick();
      check("hold_pending_t1", 64'(hall_up_pending[3]), 64'd1);
      repeat (4) tick();
      hall_up_rqst = '0;
      wait_drain("hold_assign", 21);
      check("hold_car1_none", 64'(car1_up_assign), 64'd0);
      serve(0, 3, 1'b1);

      // Tie at floor 4 twice: round-robin hands the second call to car1.
      do_reset();
      car0_floor = 4'd4; car1_floor = 4'd4;
      call(2, 1'b0, "rr_first", k);
      call(8, 1'b0, "rr_second", k);
      serve(0, 2, 1'b0);
      serve(1, 8, 1'b0);

      // Car1 takes down 9, then drops out of service; the call moves to car0.
      car0_floor = 4'd0; car1_floor = 4'd8;
      call(9, 1'b0, "pre_release", k);
      car_enable = 2'b01;
      expect_call(9, 1'b0, k);
      tick();
      check("release_c1_clr", 64'(car1_dn_assign), 64'd0);
      check("release_pending_kept", 64'(hall_dn_pending[9]), 64'd1);
      wait_drain("release_redispatch", 25);
      car_enable = 2'b11;
      serve(0, 9, 1'b0);

      // Nonexistent calls never latch.
      hall_up_rqst[11] = 1'b1; hall_dn_rqst[0] = 1'b1;
      tick();
      hall_up_rqst = '0; hall_dn_rqst = '0;
      repeat (3) tick();
      check("invalid_up_pend", 64'(hall_up_pending), 64'd0);
      check("invalid_dn_pend", 64'(hall_dn_pending), 64'd0);

      // Open door facing up at floor 5 swallows an up request there.
      car0_floor = 4'd5; car0_direction = 1'b1; car0_door_open = 1'b1;
      hall_up_rqst[5] = 1'b1;
      tick();
      hall_up_rqst = '0; car0_door_open = 1'b0;
      check("suppress_pend", 64'(hall_up_pending), 64'd0);

      // No car in service: call stays lit and unassigned.
      car_enable = 2'b00;
      tick();
      call(5, 1'b1, "no_cars", k);
      check("no_cars_k", 64'(k + 1), 64'd0);
      repeat (30) tick();
      check("no_cars_pend_kept", 64'(hall_up_pending[5]), 64'd1);
      hall_dn_rqst[4] = 1'b1; hall_dn_rqst[7] = 1'b1;
      tick();
      hall_dn_rqst = '0;
      check("three_pending", 64'({hall_up_pending, hall_dn_pending}), 64'({12'h020, 12'h090}));

      // Asynchronous reset mid-scan drops everything at once; a held button relatches afterwards.
      hall_up_rqst[2] = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midscan_reset");
      exp_q.delete(); rr_model = 1'b0; exp_cnt[0] = 0; exp_cnt[1] = 0;
      car_enable = 2'b11; car0_floor = 4'd0; car1_floor = 4'd6;
      tick();
      expect_call(2, 1'b1, k);
      rst_n = 1'b1;
      tick();
      check("relatch_pending", 64'(hall_up_pending[2]), 64'd1);
      hall_up_rqst = '0;
      wait_drain("relatch_assign", 2 * N + 3);
      serve(0, 2, 1'b1);

      // Randomized single calls against the cost model, each one served before the next.
      for (int it = 0; it < 24; it++) begin
         car0_floor = 4'($urandom_range(0, N - 1));
         car1_floor = 4'($urandom_range(0, N - 1));
         car0_direction = 1'($urandom_range(0, 1));
         car1_direction = 1'($urandom_range(0, 1));
         car0_motion = 1'($urandom_range(0, 1));
         car1_motion = 1'($urandom_range(0, 1));
         up = 1'($urandom_range(0, 1));
         f = up ? int'($urandom_range(0, N - 2)) : int'($urandom_range(1, N - 1));
         call(f, up, "rand", k);
         if (k >= 0) serve(k, f, up);
      end
`ifdef DISPATCH_STATS_EN
      check("stats_cnt0", 64'(car0_assign_cnt), 64'(exp_cnt[0]));
      check("stats_cnt1", 64'(car1_assign_cnt), 64'(exp_cnt[1]));
`endif
      check("final_pend_up", 64'(hall_up_pending), 64'd0);
      check("final_pend_dn", 64'(hall_dn_pending), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
